// File: rtl/chunked_borrow_subtractor_pkg.sv
// Shared types and defaults for the chunked borrow subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chunked_borrow_subtractor_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/chunked_borrow_subtractor_bla.sv
// Borrow-lookahead network: every borrow expanded directly from p/g/b_in.
// Latency: purely combinational.
// Backpressure: none.
module borrow_look_ahead_logic
  import chunked_borrow_subtractor_pkg::*;
#(
  parameter int NUMBITS = DEF_CHUNK
) (
  input  logic [NUMBITS-1:0] p,
  input  logic [NUMBITS-1:0] g,
  input  logic               b_in,
  output logic [NUMBITS:0]   br
);

  logic acc;
  logic pp;

  // br[i+1] = g_i | p_i g_{i-1} | ... | p_i..p_0 b_in, no ripple between bits
  always_comb begin
    br    = '0;
    acc   = 1'b0;
    pp    = 1'b0;
    br[0] = b_in;
    for (int i = 0; i < NUMBITS; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc       = acc | (pp & b_in);
      br[i + 1] = acc;
    end
  end

endmodule

// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle a - b - b_in, one CHUNK-bit lookahead group per cycle, LS chunk first.
// Latency: out_valid from WIDTH/CHUNK cycles after the acceptance edge.
// Backpressure: result held in DONE until out_ready; no new operands until then.
module chunked_borrow_subtractor
  import chunked_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  sub_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, diff_r, diff_nxt;
  logic             borrow_r, b_out_r, zero_r;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] a_c, b_c, p, g, d;
  logic [CHUNK:0]   br;
  logic             last;

  assign last = (idx == IDXW'(NUM_CHUNKS - 1));

  // Select the current chunk, form propagate/generate, and merge its difference bits
  always_comb begin
    a_c      = a_r[int'(idx) * CHUNK +: CHUNK];
    b_c      = b_r[int'(idx) * CHUNK +: CHUNK];
    g        = ~a_c & b_c;
    p        = ~(a_c ^ b_c);
    d        = a_c ^ b_c ^ br[CHUNK-1:0];
    diff_nxt = diff_r;
    diff_nxt[int'(idx) * CHUNK +: CHUNK] = d;
  end

  borrow_look_ahead_logic #(
    .NUMBITS (CHUNK)
  ) u_bla (
    .p    (p),
    .g    (g),
    .b_in (borrow_r),
    .br   (br)
  );

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Operand capture and per-chunk result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      idx      <= '0;
      diff_r   <= '0;
      b_out_r  <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= b_in;
            idx      <= '0;
            diff_r   <= '0;
            b_out_r  <= 1'b0;
            zero_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          diff_r   <= diff_nxt;
          borrow_r <= br[CHUNK];
          idx      <= last ? '0 : idx + IDXW'(1);
          if (last) begin
            b_out_r <= br[CHUNK];
            zero_r  <= (diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff  = diff_r;
  assign b_out = b_out_r;
  assign zero  = zero_r;

endmodule
